// File: rtl/circle_seg7_top.sv
// ============================================================================
// circle_seg7_top : running-segment animation around six 7-segment displays
// Revision 1.0
// ============================================================================
`default_nettype none

module counter #(
  parameter int WIDTH    = 4,
  parameter int COUNT_TO = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);
  localparam logic [WIDTH-1:0] C_TERM = WIDTH'(COUNT_TO);

  logic [WIDTH-1:0] count_q, count_d;

  assign overflow_o = (count_q == C_TERM);
  assign count_d    = overflow_o ? '0 : count_q + WIDTH'(1);
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end
endmodule

module led #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 step_i,
  output logic                 row_o,
  output logic                 dir_o,
  output logic [COL_WIDTH-1:0] curr_display_o
);
  localparam logic [0:0]           ROW_TOP = 1'b0;
  localparam logic [0:0]           ROW_BOT = 1'b1;
  localparam logic [COL_WIDTH-1:0] C_LAST  = COL_WIDTH'(NUM_OF_DISPLAYS - 1);

  logic [0:0]           row_q, row_d;
  logic                 dir_q, dir_d;
  logic [COL_WIDTH-1:0] curr_q, curr_d;

  always_comb begin
    row_d  = row_q;
    dir_d  = dir_q;
    curr_d = curr_q;
    if (step_i) begin
      case (row_q)
        ROW_TOP: begin
          // The last display turns the corner instead of advancing.
          if (curr_q == C_LAST) begin
            row_d = ROW_BOT;
            dir_d = 1'b0;
          end else begin
            curr_d = curr_q + COL_WIDTH'(1);
          end
        end
        default: begin
          if (curr_q == '0) begin
            row_d = ROW_TOP;
            dir_d = 1'b1;
          end else begin
            curr_d = curr_q - COL_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q  <= ROW_TOP;
      dir_q  <= 1'b1;
      curr_q <= '0;
    end else begin
      row_q  <= row_d;
      dir_q  <= dir_d;
      curr_q <= curr_d;
    end
  end

  assign row_o          = row_q;
  assign dir_o          = dir_q;
  assign curr_display_o = curr_q;
endmodule

module seg7_driver #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = 3
) (
  input  logic                         row_i,
  input  logic [COL_WIDTH-1:0]         curr_display_i,
  output logic [NUM_OF_DISPLAYS*8-1:0] seg7_o
);
  localparam logic [7:0] C_SEG_A = 8'hFE;
  localparam logic [7:0] C_SEG_D = 8'hF7;
  localparam logic [7:0] C_BLANK = 8'hFF;

  for (genvar i = 0; i < NUM_OF_DISPLAYS; i++) begin : g_disp
    assign seg7_o[8*i +: 8] = (curr_display_i == COL_WIDTH'(i))
                              ? (row_i ? C_SEG_D : C_SEG_A) : C_BLANK;
  end
endmodule

module circle_seg7_top #(
  parameter int WIDTH           = 4,
  parameter int COUNT_TO        = 9,
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [WIDTH-1:0]             count_o,
  output logic                         overflow_o,
  output logic                         row_o,
  output logic                         dir_o,
  output logic [COL_WIDTH-1:0]         curr_display_o,
  output logic [NUM_OF_DISPLAYS*8-1:0] seg7_o
);
  counter #(
    .WIDTH    (WIDTH),
    .COUNT_TO (COUNT_TO)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  led #(
    .NUM_OF_DISPLAYS (NUM_OF_DISPLAYS),
    .COL_WIDTH       (COL_WIDTH)
  ) u_led (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .step_i         (overflow_o),
    .row_o          (row_o),
    .dir_o          (dir_o),
    .curr_display_o (curr_display_o)
  );

  seg7_driver #(
    .NUM_OF_DISPLAYS (NUM_OF_DISPLAYS),
    .COL_WIDTH       (COL_WIDTH)
  ) u_seg7 (
    .row_i          (row_o),
    .curr_display_i (curr_display_o),
    .seg7_o         (seg7_o)
  );
endmodule

`default_nettype wire

// File: tb/tb_circle_seg7_top.sv
// ============================================================================
// tb_circle_seg7_top : self-checking bench for circle_seg7_top
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_circle_seg7_top;
  localparam int WIDTH    = 4;
  localparam int COUNT_TO = 9;
  localparam int N        = 6;
  localparam int CW       = 3;

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b0;
  logic [WIDTH-1:0] count_o;
  logic            overflow_o;
  logic            row_o;
  logic            dir_o;
  logic [CW-1:0]   curr_display_o;
  logic [N*8-1:0]  seg7_o;

  circle_seg7_top #(
    .WIDTH           (WIDTH),
    .COUNT_TO        (COUNT_TO),
    .NUM_OF_DISPLAYS (N),
    .COL_WIDTH       (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .row_o          (row_o),
    .dir_o          (dir_o),
    .curr_display_o (curr_display_o),
    .seg7_o         (seg7_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  cnt;
    logic        ovf;
    logic        row;
    logic        dir;
    logic [2:0]  curr;
    logic [47:0] seg;
  } obs_t;

  typedef struct {
    int         t;
    logic [3:0] cnt;
    logic       ovf;
    logic       row;
    logic       dir;
    logic [2:0] curr;
  } vec_t;

  vec_t vecs[10];
  obs_t sb_q[$];
  int   t;
  bit   tvalid = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [47:0] seg_of(logic row, logic [2:0] curr);
    logic [47:0] s;
    s = '1;
    for (int i = 0; i < N; i++)
      if (int'(curr) == i) s[8*i +: 8] = row ? 8'hF7 : 8'hFE;
    return s;
  endfunction

  // Position derived from elapsed cycles, independent of any FSM.
  function automatic obs_t model(int tt);
    obs_t o;
    int   s;
    s      = (tt / (COUNT_TO + 1)) % (2 * N);
    o.cnt  = 4'(tt % (COUNT_TO + 1));
    o.ovf  = ((tt % (COUNT_TO + 1)) == COUNT_TO);
    o.row  = (s >= N);
    o.dir  = !o.row;
    o.curr = 3'((s < N) ? s : (2 * N - 1 - s));
    o.seg  = seg_of(o.row, o.curr);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cnt  = count_o;
    o.ovf  = overflow_o;
    o.row  = row_o;
    o.dir  = dir_o;
    o.curr = curr_display_o;
    o.seg  = seg7_o;
    return o;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
  endtask

  task automatic step();
    obs_t e;
    @(posedge clk_i);
    if (!rst_ni) begin
      t      = 0;
      tvalid = 1'b1;
    end else if (tvalid) begin
      t++;
    end
    if (tvalid) sb_q.push_back(model(t));
    #1;
    if (tvalid) begin
      e = sb_q.pop_front();
      check("cycle", 64'(observe()), 64'(e));
      check("onehot", 64'($countones(~seg7_o)), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (5) step();
    rst_ni = 1'b1;
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (t < target && guard < 1000) begin
      step();
      guard++;
    end
    if (t != target) check("run_to_timeout", 64'(t), 64'(target));
  endtask

  task automatic check_vec(string name, vec_t v);
    obs_t e;
    e.cnt  = v.cnt;
    e.ovf  = v.ovf;
    e.row  = v.row;
    e.dir  = v.dir;
    e.curr = v.curr;
    e.seg  = seg_of(v.row, v.curr);
    check(name, 64'(observe()), 64'(e));
  endtask

  initial begin
    vec_t v;
    // {t since reset, count, overflow, row, dir, curr}
    vecs[0] = '{0,   4'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[1] = '{9,   4'd9, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[2] = '{19,  4'd9, 1'b1, 1'b0, 1'b1, 3'd1};
    vecs[3] = '{50,  4'd0, 1'b0, 1'b0, 1'b1, 3'd5};
    vecs[4] = '{59,  4'd9, 1'b1, 1'b0, 1'b1, 3'd5};
    vecs[5] = '{60,  4'd0, 1'b0, 1'b1, 1'b0, 3'd5};
    vecs[6] = '{70,  4'd0, 1'b0, 1'b1, 1'b0, 3'd4};
    vecs[7] = '{119, 4'd9, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[8] = '{120, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[9] = '{125, 4'd5, 1'b0, 1'b0, 1'b1, 3'd0};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_to(vecs[i].t);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-run reset while on the bottom row at display 3, count 4.
    do_reset();
    run_to(84);
    v = '{84, 4'd4, 1'b0, 1'b1, 1'b0, 3'd3};
    check_vec("pre_reset", v);
    rst_ni = 1'b0;
    step();
    v = '{0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    check_vec("mid_reset", v);
    rst_ni = 1'b1;
    step();
    v = '{1, 4'd1, 1'b0, 1'b0, 1'b1, 3'd0};
    check_vec("restart1", v);
    step();
    v = '{2, 4'd2, 1'b0, 1'b0, 1'b1, 3'd0};
    check_vec("restart2", v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
